// File: rtl/mm_arb_pkg.sv
// Shared types and helpers for the matrix-multiply job arbiter.
// No logic here: state encoding, index-width helper and watchdog counter width.
// Backpressure: n/a.
package mm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RUN     = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  // Width of the RUN-cycle watchdog counter; TIMEOUT must fit below 2**WD_CNT_W.
  localparam int WD_CNT_W = 16;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mm_job_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping at NREQ.
// Latency: combinational.
// Backpressure: none; result only meaningful while pick_vld is high.
module rr_pick
  import mm_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] pick_oh,
  output logic [IW-1:0]   pick_idx,
  output logic            pick_vld
);

  // Scan ptr, ptr+1, ... mod NREQ; the first requester found wins.
  always_comb begin
    int j;
    j        = 0;
    pick_oh  = '0;
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!pick_vld && req[j]) begin
        pick_vld   = 1'b1;
        pick_idx   = IW'(j);
        pick_oh[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mm_job_arbiter.sv
// Round-robin owner of one shared matrix-multiply engine; optional RUN watchdog via MM_ARB_WATCHDOG_EN.
// Latency: grant + eng_start one edge after req is seen in IDLE; done one edge after eng_done; 3 cycles/job overhead.
// Backpressure: requesters hold req until their done pulse; others wait in queue while the engine is owned.
module mm_job_arbiter
  import mm_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DIM     = 2,
  parameter int TIMEOUT = 64,
  parameter int CW      = 16,
  localparam int IW = idx_w(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic [IW-1:0]   eng_sel,
  output logic            eng_start,
  input  logic            eng_done,
  output logic [7:0]      eng_dim,
  output logic            busy,
  output logic [CW-1:0]   job_count
`ifdef MM_ARB_WATCHDOG_EN
  ,
  output logic            eng_abort,
  output logic            err,
  output logic            err_sticky
`endif
);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT >= 2**WD_CNT_W) begin : g_bad_params
    $error("mm_job_arbiter: NREQ must be 2..8 and TIMEOUT must fit the watchdog counter");
  end

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] owner_oh_q, owner_oh_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   count_d;
  logic [NREQ-1:0] gnt_d, done_d;
  logic            start_d, busy_d;

  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;

`ifdef MM_ARB_WATCHDOG_EN
  logic [WD_CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic                timeout;
`endif

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req      (req),
    .ptr      (ptr_q),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  assign eng_sel = owner_q;
  assign eng_dim = 8'(DIM);

  // Next state plus the next value of every registered output, decoded from the next state.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    owner_oh_d = owner_oh_q;
    ptr_d      = ptr_q;
    count_d    = job_count;
`ifdef MM_ARB_WATCHDOG_EN
    wd_cnt_d   = wd_cnt_q;
    timeout    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          owner_d    = pick_idx;
          owner_oh_d = pick_oh;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        state_d = ST_RUN;
`ifdef MM_ARB_WATCHDOG_EN
        wd_cnt_d = '0;
`endif
      end
      ST_RUN: begin
        // A completion in the same cycle as the timeout counts as a normal finish.
        if (eng_done) begin
          state_d = ST_RELEASE;
          count_d = job_count + CW'(1);
        end
`ifdef MM_ARB_WATCHDOG_EN
        else if (wd_cnt_q == WD_CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_RELEASE;
          timeout = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_CNT_W'(1);
        end
`endif
      end
      ST_RELEASE: begin
        ptr_d   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    gnt_d   = (state_d != ST_IDLE)    ? owner_oh_d : '0;
    done_d  = (state_d == ST_RELEASE) ? owner_oh_d : '0;
    start_d = (state_d == ST_GRANT);
    busy_d  = (state_d != ST_IDLE);
  end

  // State, owner, pointer and output registers; reset drops the grant at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      owner_oh_q <= '0;
      ptr_q      <= '0;
      job_count  <= '0;
      gnt        <= '0;
      done       <= '0;
      eng_start  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      owner_oh_q <= owner_oh_d;
      ptr_q      <= ptr_d;
      job_count  <= count_d;
      gnt        <= gnt_d;
      done       <= done_d;
      eng_start  <= start_d;
      busy       <= busy_d;
    end
  end

`ifdef MM_ARB_WATCHDOG_EN
  // RUN-cycle watchdog: abort/err pulse with the forced release, sticky flag until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q   <= '0;
      eng_abort  <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      wd_cnt_q   <= wd_cnt_d;
      eng_abort  <= timeout;
      err        <= timeout;
      err_sticky <= err_sticky | timeout;
    end
  end
`endif

endmodule

// File: tb/tb_mm_job_arbiter.sv
// Directed bench for mm_job_arbiter with a job-level reference model and per-cycle output compare.
// Engine and requesters are modelled; expected values come from the model and hand-computed literals.
// Backpressure: requesters drop req on their done pulse, optionally re-raising one cycle later.
`timescale 1ns/1ps
module tb_mm_job_arbiter;

  localparam int NREQ = 4;
  localparam int DIM  = 2;
  localparam int TO   = 64;
  localparam int CW   = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] gnt, done;
  logic [1:0]      eng_sel;
  logic            eng_start, eng_done;
  logic [7:0]      eng_dim;
  logic            busy;
  logic [CW-1:0]   job_count;
`ifdef MM_ARB_WATCHDOG_EN
  logic            eng_abort, err, err_sticky;
`endif

  logic eng_auto = 1'b0;
  logic eng_spur = 1'b0;
  assign eng_done = eng_auto | eng_spur;

  always #5 clk = ~clk;

  mm_job_arbiter #(.NREQ(NREQ), .DIM(DIM), .TIMEOUT(TO), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .done      (done),
    .eng_sel   (eng_sel),
    .eng_start (eng_start),
    .eng_done  (eng_done),
    .eng_dim   (eng_dim),
    .busy      (busy),
    .job_count (job_count)
`ifdef MM_ARB_WATCHDOG_EN
    ,
    .eng_abort  (eng_abort),
    .err        (err),
    .err_sticky (err_sticky)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (job level) ----------------
  int  m_owner = -1;   // current engine owner, -1 when nobody holds it
  int  m_age   = 0;    // cycles since this owner's grant (0 = start cycle)
  int  m_ptr   = 0;
  int  m_count = 0;
  int  m_sel   = 0;
  bit  m_fin   = 1'b0; // completion cycle of the current job
  bit  m_abort = 1'b0;
  bit  m_sticky = 1'b0;
  int  m_order[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner = -1; m_age = 0; m_ptr = 0; m_count = 0; m_sel = 0;
      m_fin = 1'b0; m_abort = 1'b0; m_sticky = 1'b0;
    end else if (m_fin) begin
      m_ptr   = (m_owner + 1) % NREQ;
      m_owner = -1;
      m_fin   = 1'b0;
      m_abort = 1'b0;
    end else if (m_owner >= 0) begin
      if (m_age >= 1 && eng_done) begin
        m_fin = 1'b1;
        m_count++;
      end
`ifdef MM_ARB_WATCHDOG_EN
      else if (m_age == TO) begin
        m_fin = 1'b1; m_abort = 1'b1; m_sticky = 1'b1;
      end
`endif
      m_age++;
    end else if (req != '0) begin
      for (int k = 0; k < NREQ; k++)
        if (m_owner < 0 && req[(m_ptr + k) % NREQ]) m_owner = (m_ptr + k) % NREQ;
      m_age = 0;
      m_sel = m_owner;
      m_order.push_back(m_owner);
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [NREQ-1:0] e_gnt, e_done;
  always @(negedge clk) begin
    e_gnt  = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
    e_done = m_fin ? e_gnt : '0;
    chk("cyc_gnt", gnt, e_gnt);
    chk("cyc_done", done, e_done);
    chk("cyc_eng_start", eng_start, (m_owner >= 0 && m_age == 0 && !m_fin));
    chk("cyc_eng_sel", eng_sel, m_sel);
    chk("cyc_busy", busy, (m_owner >= 0));
    chk("cyc_job_count", job_count, CW'(m_count));
    chk("cyc_eng_dim", eng_dim, DIM);
`ifdef MM_ARB_WATCHDOG_EN
    chk("cyc_eng_abort", eng_abort, m_fin && m_abort);
    chk("cyc_err", err, m_fin && m_abort);
    chk("cyc_err_sticky", err_sticky, m_sticky);
`endif
  end

  // ---------------- engine model ----------------
  int eng_lat = 5;
  int eng_cnt = 0;
  always @(negedge clk) begin
    eng_auto = 1'b0;
    if (reset) eng_cnt = 0;
    else if (eng_start && eng_lat > 0) eng_cnt = eng_lat;
    else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) eng_auto = 1'b1;
    end
  end

  // ---------------- requesters and observation ----------------
  logic [NREQ-1:0] keep = '0;
  logic [NREQ-1:0] reraise = '0;
  int              dut_order[$];
  logic [NREQ-1:0] dut_done[$];
  int              cyc = 0, t_start = 0, t_done = 0, t_err = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++)
      if (reraise[i]) begin req[i] = 1'b1; reraise[i] = 1'b0; end
    for (int i = 0; i < NREQ; i++)
      if (done[i]) begin req[i] = 1'b0; if (keep[i]) reraise[i] = 1'b1; end
    if (eng_start) begin dut_order.push_back(int'(eng_sel)); t_start = cyc; end
    if (done != '0) begin dut_done.push_back(done); t_done = cyc; end
`ifdef MM_ARB_WATCHDOG_EN
    if (err) t_err = cyc;
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic mid();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    mid();
    reset = 1'b1; req = '0; keep = '0; reraise = '0; eng_spur = 1'b0;
    mid();
    mid();
    reset = 1'b0;
    dut_order.delete(); dut_done.delete(); m_order.delete();
  endtask

  task automatic wait_count(input int target, input int budget, input string name);
    int n = 0;
    while (job_count !== CW'(target) && n < budget) begin mid(); n++; end
    chk(name, job_count, target);
  endtask

  task automatic chk_order(input string name, input int exp[], input int len);
    chk({name, "_dut_len"}, dut_order.size(), len);
    chk({name, "_model_len"}, m_order.size(), len);
    for (int i = 0; i < len; i++) begin
      if (i < dut_order.size()) chk({name, "_dut"}, dut_order[i], exp[i]);
      if (i < m_order.size())   chk({name, "_model"}, m_order[i], exp[i]);
    end
  endtask

  int exp3[] = '{0, 1, 2, 3, 0};
  int exp4[] = '{0, 3, 0};
  int exp5[] = '{0, 1};

  initial begin
    int n;
    // 1: reset values, then async reset in the middle of a job
    mid();
    chk("t1_rst_gnt", gnt, 0);
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_count", job_count, 0);
    mid();
    reset = 1'b0;
    req = 4'b0100;
    n = 0;
    while (gnt !== 4'b0100 && n < 20) begin mid(); n++; end
    chk("t1_gnt_before_reset", gnt, 4'b0100);
    mid();
    mid();
    reset = 1'b1;
    #1;
    chk("t1_async_gnt", gnt, 0);
    chk("t1_async_busy", busy, 0);
    chk("t1_async_eng_sel", eng_sel, 0);
    chk("t1_async_eng_start", eng_start, 0);
    req = '0;
    mid();
    reset = 1'b0;
    dut_order.delete(); dut_done.delete(); m_order.delete();

    // 2: single requester 2, engine done 5 cycles after start
    req = 4'b0100;
    wait_count(1, 40, "t2_count");
    mid(); mid(); mid();
    chk("t2_starts", dut_order.size(), 1);
    chk("t2_sel", eng_sel, 2);
    chk("t2_done_pulses", dut_done.size(), 1);
    if (dut_done.size() > 0) chk("t2_done_val", dut_done[0], 4'b0100);
    chk("t2_start_to_done", t_done - t_start, 6);
    chk("t2_req_dropped", req, 0);

    // 3: all four requesting, re-raising after each done
    do_reset();
    keep = 4'b1111;
    req  = 4'b1111;
    wait_count(5, 200, "t3_count");
    keep = '0;
    req  = '0;
    mid(); mid(); mid(); mid();
    chk_order("t3_order", exp3, 5);
    chk("t3_count_final", job_count, 5);

    // 4: ptr=1 with requesters 3 and 0; spurious eng_done while idle
    do_reset();
    req = 4'b0001;
    wait_count(1, 40, "t4_first");
    mid(); mid();
    eng_spur = 1'b1;
    mid();
    eng_spur = 1'b0;
    mid();
    chk("t4_spur_busy", busy, 0);
    chk("t4_spur_count", job_count, 1);
    req = 4'b1001;
    wait_count(3, 80, "t4_count");
    mid(); mid(); mid();
    chk_order("t4_order", exp4, 3);

    // 5: owner drops req during RUN; job still completes, then the other requester
    do_reset();
    req = 4'b0011;
    n = 0;
    while (!(gnt === 4'b0001 && eng_start === 1'b0) && n < 20) begin mid(); n++; end
    chk("t5_in_run", gnt, 4'b0001);
    req[0] = 1'b0;
    wait_count(2, 80, "t5_count");
    mid(); mid(); mid();
    chk("t5_done_pulses", dut_done.size(), 2);
    if (dut_done.size() > 1) begin
      chk("t5_done0", dut_done[0], 4'b0001);
      chk("t5_done1", dut_done[1], 4'b0010);
    end
    chk_order("t5_order", exp5, 2);

`ifdef MM_ARB_WATCHDOG_EN
    // 6: engine never finishes; watchdog forces the release
    do_reset();
    eng_lat = 0;
    req = 4'b0001;
    n = 0;
    while (err_sticky !== 1'b1 && n < 150) begin mid(); n++; end
    chk("t6_sticky_set", err_sticky, 1);
    chk("t6_start_to_err", t_err - t_start, TO + 1);
    mid(); mid(); mid();
    chk("t6_count_unchanged", job_count, 0);
    chk("t6_done_pulses", dut_done.size(), 1);
    if (dut_done.size() > 0) chk("t6_done_val", dut_done[0], 4'b0001);
    chk("t6_sticky_held", err_sticky, 1);
    do_reset();
    chk("t6_sticky_cleared", err_sticky, 0);
    eng_lat = 5;
`endif

    mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
